// File: rtl/pipe_skid_reg.sv
// Circular-buffer pipeline register with valid/ready handshakes on both sides.
// Ready and valid come from flops, so there is no combinational path between the two handshakes.
module pipe_skid_reg #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_COUNT  = CW'(1);
  localparam logic [PW-1:0] ONE_PTR    = PW'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic             push_s;
  logic             pop_s;
  logic [CW-1:0]    count_nxt_s;

  // Handshake decode and next occupancy; flush suppresses both transfers.
  always_comb begin
    push_s      = 1'b0;
    pop_s       = 1'b0;
    count_nxt_s = count_r;
    if (!flush) begin
      push_s = in_valid && in_ready_r;
      pop_s  = out_valid_r && out_ready;
    end else begin
      push_s = 1'b0;
      pop_s  = 1'b0;
    end
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + ONE_COUNT;
      2'b01:   count_nxt_s = count_r - ONE_COUNT;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, occupancy and the registered ready/valid flags.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr_r    <= '0;
      wr_ptr_r    <= '0;
      count_r     <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_PTR;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_PTR;
      end
      count_r     <= count_nxt_s;
      in_ready_r  <= (count_nxt_s != FULL_COUNT);
      out_valid_r <= (count_nxt_s != '0);
    end
  end

  // Payload storage; contents are not cleared, pointers make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = mem_r[rd_ptr_r];
  assign count     = count_r;

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter WIDTH, default 64: payload width in bits, at least 1.
REQ-002 Parameter DEPTH, default 2: number of buffer entries; a power of two, at least 2.
REQ-003 Port clk, input, 1 bit: clock. All state changes on the rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port flush, input, 1 bit: synchronous discard of all buffered entries.
REQ-006 Port in_valid, input, 1 bit: upstream offers in_data.
REQ-007 Port in_data, input, WIDTH bits: upstream payload.
REQ-008 Port in_ready, output, 1 bit: the block can accept a beat this cycle.
REQ-009 Port out_valid, output, 1 bit: out_data holds a valid beat.
REQ-010 Port out_data, output, WIDTH bits: payload at the head of the buffer.
REQ-011 Port out_ready, input, 1 bit: downstream accepts the head beat.
REQ-012 Port count, output, $clog2(DEPTH)+1 bits: number of occupied entries.

Function
REQ-013 Storage SHALL be a circular buffer: DEPTH entries of WIDTH bits, with read pointer rd_ptr and write pointer wr_ptr, each $clog2(DEPTH) bits, plus a count register.
REQ-014 Push SHALL occur when in_valid && in_ready && !flush. Pop SHALL occur when out_valid && out_ready && !flush.
REQ-015 in_ready SHALL equal (count != DEPTH). It SHALL be decoded from registered state only, with no combinational path from out_ready.
REQ-016 out_valid SHALL equal (count != 0). out_data SHALL be the entry at rd_ptr, and SHALL be don't-care when out_valid is 0.
REQ-017 On a push, the entry at wr_ptr SHALL be written and wr_ptr SHALL advance by one, wrapping modulo DEPTH.
REQ-018 On a pop, rd_ptr SHALL advance by one, wrapping modulo DEPTH.
REQ-019 count SHALL update as follows: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop or on neither.
REQ-020 Latency SHALL be one cycle: a beat pushed at edge N is visible on out_valid/out_data after edge N.
REQ-021 There SHALL be no combinational bypass from in_data to out_data.
REQ-022 Full boundary (count == DEPTH): in_ready is 0, so no push. A pop that cycle makes in_ready 1 in the next cycle. The head beat SHALL be unchanged while out_ready is 0.
REQ-023 Empty boundary (count == 0): out_valid is 0, so no pop. An incoming beat is accepted and appears in the next cycle.
REQ-024 Simultaneous push and pop at 0 < count < DEPTH: both pointers SHALL advance and count SHALL hold. Throughput SHALL be one beat per cycle indefinitely.
REQ-025 Flush SHALL have priority over push and pop. At the edge it SHALL set rd_ptr = wr_ptr = 0 and count = 0, with no push or pop performed.
REQ-026 While flush is high, in_ready SHALL still reflect the pre-flush count, but the offered beat SHALL be dropped.
REQ-027 Beats SHALL leave in the order they arrived. No beat SHALL be duplicated or lost, except through flush or reset.
REQ-028 Upstream SHALL hold in_valid/in_data stable until accepted. The block does not depend on this for correctness.

Reset
REQ-029 While reset is high at a clock edge: rd_ptr = 0, wr_ptr = 0, count = 0, out_valid = 0, in_ready = 1.
REQ-030 Reset SHALL have priority over flush, push and pop.
REQ-031 Entry storage need not be cleared by reset.
REQ-032 Reset mid-operation SHALL discard all buffered beats. The first beat pushed after reset deasserts SHALL be the first beat output.

Verification
REQ-033 Fill to full, DEPTH=2, out_ready=0: push 0xA, 0xB -> count=2, in_ready=0. A third offer 0xC is held upstream. out_data stays 0xA.
REQ-034 Streaming: in_valid=1 with data 1,2,3,... and out_ready=1 for 20 cycles -> output 1,2,3,... in order, one per cycle after the first-cycle latency. count stays at 1.
REQ-035 Pointer wrap, DEPTH=4: push 6 beats, pop 6 beats, interleaved randomly -> order preserved across the wrap. count returns to 0 and out_valid=0.
REQ-036 Flush with a simultaneous push while count=2 -> next cycle count=0, out_valid=0, and the pushed beat never appears on the output.
REQ-037 Reset asserted with count=DEPTH and out_ready=1 -> next cycle count=0, in_ready=1. A push of 0x55 after reset outputs 0x55 first.
REQ-038 Random valid/ready back-pressure over 10k cycles against a scoreboard model, WIDTH=1 and WIDTH=64 -> zero mismatches and zero lost beats. in_ready never depends on out_ready in the same cycle.
